// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the serial pattern detector.
// The helpers build the KMP transition table from the PATTERN parameter. They are
// only ever evaluated in constant context, so they cost no logic.
package seq_det_pkg;

  localparam int MOORE = 0;
  localparam int MEALY = 1;

  // Pattern bit i, counted in arrival order, lives at pat[len-1-i].
  // Returns the length of the longest pattern prefix that is a suffix of
  // (first k pattern bits followed by bit b).
  function automatic int kmp_next(input logic [15:0] pat, input int len,
                                  input int k, input logic b);
    int   best;
    int   pos;
    logic ok;
    logic sb;
    best = 0;
    for (int m = 1; m <= 16; m++) begin
      if (m <= len && m <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < m) begin
            pos = k + 1 - m + i;
            if (pos == k) sb = b;
            else sb = pat[4'(len - 1 - pos)];
            if (sb != pat[4'(len - 1 - i)]) ok = 1'b0;
          end
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

  // Longest proper prefix of the pattern that is also a suffix of it. This is
  // where an overlapping detector resumes after a full match.
  function automatic int kmp_border(input logic [15:0] pat, input int len);
    int   best;
    logic ok;
    best = 0;
    for (int m = 1; m < 16; m++) begin
      if (m < len) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < m) begin
            if (pat[4'(len - 1 - i)] != pat[4'(m - 1 - i)]) ok = 1'b0;
          end
        end
        if (ok) best = m;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear first, then increment unless the counter is already all ones.
  always_comb begin
    count_d = count_q;
    if (clr_i) count_d = '0;
    else if (inc_i && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector. The state is the length of the pattern
// prefix matched so far. Transitions come from a KMP table that is built at
// elaboration. In Moore mode, S(PAT_LEN) is a real state that drives w. In Mealy
// mode, w is raised combinationally on the completing bit, and the state never
// reaches S(PAT_LEN). dbg_state exposes the state register for observation.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int          PAT_LEN = 5,
  parameter logic [15:0] PATTERN = 16'b0000_0000_0001_0110,
  parameter int          MODE    = 0,
  parameter int          OVERLAP = 1,
  parameter int          CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           j,
  input  logic                           clr_count,
  output logic                           w,
  output logic [CNT_W-1:0]               match_count,
  output logic [$clog2(PAT_LEN+1)-1:0]   dbg_state
);

  localparam int SW = $clog2(PAT_LEN + 1);
  localparam logic [SW-1:0] FULL   = SW'(PAT_LEN);
  localparam logic [SW-1:0] BORDER = SW'(kmp_border(PATTERN, PAT_LEN));

  // Reject parameter values the table construction cannot handle.
  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
    $error("seq_detector_param: PAT_LEN must be in 2..16");
  end
  if (MODE != MOORE && MODE != MEALY) begin : g_bad_mode
    $error("seq_detector_param: MODE must be 0 (Moore) or 1 (Mealy)");
  end
  if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_ovl
    $error("seq_detector_param: OVERLAP must be 0 or 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  // Transition table: tab[k][b] = next prefix length from S(k) on bit b.
  logic [SW-1:0] tab [PAT_LEN+1][2];

  for (genvar gk = 0; gk <= PAT_LEN; gk++) begin : g_k
    for (genvar gb = 0; gb < 2; gb++) begin : g_b
      localparam int NXT = kmp_next(PATTERN, PAT_LEN, gk, 1'(gb));
      assign tab[gk][gb] = SW'(NXT);
    end
  end

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [SW-1:0] base;
  logic [SW-1:0] nxt;
  logic          match;

  // Next-state and match decode. A non-overlapping Moore detector treats
  // S(PAT_LEN) as S0. A Mealy detector never enters S(PAT_LEN): it jumps
  // straight to the border (overlap) or to S0.
  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    base    = state_q;
    nxt     = '0;
    if (MODE == MOORE && OVERLAP == 0 && state_q == FULL) base = '0;
    for (int k = 0; k <= PAT_LEN; k++) begin
      if (base == SW'(k)) nxt = tab[k][j];
    end
    if (en) begin
      match = (nxt == FULL);
      if (match && MODE == MEALY) state_d = (OVERLAP != 0) ? BORDER : '0;
      else                        state_d = nxt;
    end
  end

  // State register; reset discards any partial match immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= '0;
    else      state_q <= state_d;
  end

  assign w         = (MODE == MOORE) ? (state_q == FULL) : match;
  assign dbg_state = state_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .clr_i   (clr_count),
    .inc_i   (match),
    .count_o (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. Five detector variants share one stimulus
// stream. A history-based reference model scans for the 10110 pattern in the
// sampled bits, and its predictions are compared against every variant.
module tb_seq_detector_param;

  localparam int PAT_LEN = 5;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic j = 1'b0;
  logic clr_count = 1'b0;
  always #5 clk = ~clk;

  logic       w_mo, w_mn, w_eo, w_en, w_c2;
  logic [7:0] cnt_mo, cnt_mn, cnt_eo, cnt_en;
  logic [1:0] cnt_c2;
  logic [2:0] st_mo, st_mn, st_eo, st_en, st_c2;

  seq_detector_param #(.MODE(0), .OVERLAP(1), .CNT_W(8)) u_moore_ov (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_count(clr_count),
    .w(w_mo), .match_count(cnt_mo), .dbg_state(st_mo));
  seq_detector_param #(.MODE(0), .OVERLAP(0), .CNT_W(8)) u_moore_no (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_count(clr_count),
    .w(w_mn), .match_count(cnt_mn), .dbg_state(st_mn));
  seq_detector_param #(.MODE(1), .OVERLAP(1), .CNT_W(8)) u_mealy_ov (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_count(clr_count),
    .w(w_eo), .match_count(cnt_eo), .dbg_state(st_eo));
  seq_detector_param #(.MODE(1), .OVERLAP(0), .CNT_W(8)) u_mealy_no (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_count(clr_count),
    .w(w_en), .match_count(cnt_en), .dbg_state(st_en));
  seq_detector_param #(.MODE(0), .OVERLAP(1), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .en(en), .j(j), .clr_count(clr_count),
    .w(w_c2), .match_count(cnt_c2), .dbg_state(st_c2));

  // Reference model state
  bit pat_seq [PAT_LEN] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit hist [$];
  int last_no = 0;
  bit exp_w_ov = 1'b0;
  bit exp_w_no = 1'b0;
  int exp_cnt_ov = 0;
  int exp_cnt_no = 0;
  int exp_cnt2 = 0;

  int checks = 0;
  int passed = 0;
  int fails = 0;

  // True when the sampled history since index start ends with the pattern.
  function automatic bit match_end(input int start);
    int n;
    n = hist.size();
    if (n - start < PAT_LEN) return 1'b0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (hist[n - PAT_LEN + i] != pat_seq[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Would sampling bit b now complete a match?
  function automatic bit predict(input int start, input bit b);
    bit r;
    hist.push_back(b);
    r = match_end(start);
    void'(hist.pop_back());
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    last_no = 0;
    exp_w_ov = 1'b0;
    exp_w_no = 1'b0;
    exp_cnt_ov = 0;
    exp_cnt_no = 0;
    exp_cnt2 = 0;
  endtask

  task automatic model_edge(input bit e, input bit b, input bit c);
    bit m_ov;
    bit m_no;
    m_ov = 1'b0;
    m_no = 1'b0;
    if (e) begin
      hist.push_back(b);
      m_ov = match_end(0);
      m_no = match_end(last_no);
      if (m_no) last_no = hist.size();
      exp_w_ov = m_ov;
      exp_w_no = m_no;
    end
    if (c) begin
      exp_cnt_ov = 0;
      exp_cnt_no = 0;
      exp_cnt2 = 0;
    end else begin
      if (m_ov && exp_cnt_ov < 255) exp_cnt_ov++;
      if (m_no && exp_cnt_no < 255) exp_cnt_no++;
      if (m_ov && exp_cnt2 < 3) exp_cnt2++;
    end
  endtask

  // Scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_mealy();
    check("mealy_ov_w", 32'(w_eo), 32'(en && predict(0, j)));
    check("mealy_no_w", 32'(w_en), 32'(en && predict(last_no, j)));
  endtask

  task automatic check_registered();
    check("moore_ov_w", 32'(w_mo), 32'(exp_w_ov));
    check("moore_no_w", 32'(w_mn), 32'(exp_w_no));
    check("cnt2_w", 32'(w_c2), 32'(exp_w_ov));
    check("moore_ov_cnt", 32'(cnt_mo), 32'(exp_cnt_ov));
    check("moore_no_cnt", 32'(cnt_mn), 32'(exp_cnt_no));
    check("mealy_ov_cnt", 32'(cnt_eo), 32'(exp_cnt_ov));
    check("mealy_no_cnt", 32'(cnt_en), 32'(exp_cnt_no));
    check("cnt2_cnt", 32'(cnt_c2), 32'(exp_cnt2));
  endtask

  // Driver: one clock of stimulus. With glitch set, j first shows the opposite
  // value inside the cycle so that the combinational Mealy output is probed.
  task automatic step(input bit e, input bit b, input bit c, input bit glitch = 1'b0);
    @(negedge clk);
    en = e;
    clr_count = c;
    if (glitch) begin
      j = ~b;
      #1;
      check_mealy();
    end
    j = b;
    #1;
    check_mealy();
    @(posedge clk);
    model_edge(e, b, c);
    #1;
    check_registered();
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic reset_pulse();
    @(negedge clk);
    en = 1'b0;
    clr_count = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_registered();
    check_mealy();
    #1;
    rst = 1'b1;
  endtask

  int   exp_seq [5] = '{1, 2, 3, 3, 3};
  logic [4:0] pv;
  bit   e_r, b_r, c_r, g_r;

  initial begin
    // Reset state at time zero, no X on any output
    #1;
    model_reset();
    check_registered();
    check_mealy();
    @(negedge clk);
    rst = 1'b1;

    // Reference stream 1,0,1,1,0,1,1,0, with a j glitch in the 5th-bit cycle
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    step(1, 0, 0, 1'b1);
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0, 1'b1);
    check("ref_moore_ov_total", 32'(cnt_mo), 32'd2);
    check("ref_moore_no_total", 32'(cnt_mn), 32'd1);

    // Reset mid-sequence discards the partial match
    reset_pulse();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    reset_pulse();
    step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    check("rst_mid_total", 32'(cnt_mo), 32'd1);

    // Qualifier low for three cycles between bits 3 and 4
    reset_pulse();
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    step(0, 1'($urandom_range(0, 1)), 0);
    step(0, 1'($urandom_range(0, 1)), 0);
    step(0, 1'($urandom_range(0, 1)), 0);
    step(1, 1, 0); step(1, 0, 0);
    check("en_gap_total", 32'(cnt_mo), 32'd1);

    // Two-bit counter saturation, then a clear on the edge of a 6th match
    reset_pulse();
    pv = 5'b10110;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 5; i++) step(1, pv[3'(4 - i)], 0);
      check("sat_cnt2", 32'(cnt_c2), 32'(exp_seq[r]));
    end
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    step(1, 0, 1);
    check("sat_clr_wins", 32'(cnt_c2), 32'd0);
    check("sat_clr_wins_w", 32'(w_c2), 32'd1);

    // Randomized traffic with occasional clears, glitches and resets
    reset_pulse();
    for (int n = 0; n < 600; n++) begin
      e_r = ($urandom_range(0, 9) != 0);
      b_r = 1'($urandom_range(0, 1));
      c_r = ($urandom_range(0, 24) == 0);
      g_r = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else step(e_r, b_r, c_r, g_r);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 5, meaning pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 5'b10110, meaning the target sequence; PATTERN[PAT_LEN-1] is the first bit received.
REQ-003 The block SHALL have parameter MODE, default 0, meaning output style: 0 = Moore, 1 = Mealy.
REQ-004 The block SHALL have parameter OVERLAP, default 1, meaning 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-005 The block SHALL have parameter CNT_W, default 8, meaning match-counter width.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The block SHALL have port en, input, 1 bit: serial-bit qualifier; j is sampled only when en=1.
REQ-009 The block SHALL have port j, input, 1 bit: serial data bit.
REQ-010 The block SHALL have port w, output, 1 bit: match indication.
REQ-011 The block SHALL have port match_count, output, CNT_W bits: number of matches detected since reset, saturating.
REQ-012 The block SHALL have port clr_count, input, 1 bit: synchronous clear of match_count.

Function
REQ-013 The block SHALL track its state as S0..S(PAT_LEN): S(k) = longest prefix of PATTERN matched so far (length k).
REQ-014 Next state on a sampled bit SHALL be the longest pattern prefix that is a suffix of (matched prefix + j), i.e. a KMP failure-function transition computed at elaboration.
REQ-015 With en=0, state, w (Moore) and match_count SHALL hold; Mealy w SHALL be 0.
REQ-016 In Moore mode, w SHALL be 1 exactly while state = S(PAT_LEN): one cycle after the edge on which the last pattern bit is sampled.
REQ-017 In Mealy mode, state SHALL range only over S0..S(PAT_LEN-1); w SHALL be combinational, 1 when en=1, state=S(PAT_LEN-1) and j = PATTERN[0]; w SHALL be 0 in all other cases.
REQ-018 With OVERLAP=1, after a match the next state SHALL be the KMP transition from the full pattern.
REQ-019 With OVERLAP=0, after a match the next state SHALL be derived from S0; in Moore mode, S(PAT_LEN) SHALL transition as S0 would on the next sampled bit.
REQ-020 match_count SHALL increment by 1 on each clock edge where a match completes; at all-ones it SHALL hold (saturate).
REQ-021 clr_count=1 SHALL zero match_count at the next edge; if a match completes on the same edge, the clear SHALL win and the result SHALL be 0.
REQ-022 Parameter values outside legal ranges SHALL cause an elaboration-time error.

Reset
REQ-023 rst=0 SHALL immediately force state to S0, match_count to 0, and Moore w to 0, independent of clk.
REQ-024 Assertion of rst mid-sequence SHALL discard any partial match; the first bit sampled after rst deasserts SHALL be treated as the first bit of a new sequence.
REQ-025 No output SHALL be X after rst is first asserted.

Structure
REQ-026 A shared package seq_det_pkg SHALL hold the mode constants (MOORE=0, MEALY=1) and the next-state (failure-function) elaboration function.
REQ-027 Counter saturation and clear SHALL be implemented in one sub-module, sat_counter, parametrised by CNT_W.
REQ-028 The state register SHALL be sized $clog2(PAT_LEN+1) bits.

Verification
REQ-029 Moore, OVERLAP=1, en=1, j=1,0,1,1,0,1,1,0 -> w=1 in the cycle after the 5th bit and after the 8th bit; match_count=2.
REQ-030 Moore, OVERLAP=0, same stimulus -> w=1 only after the 5th bit; match_count=1.
REQ-031 Mealy, OVERLAP=1, same stimulus -> w=1 during the cycles presenting bits 5 and 8 (before the edge); w=0 when j toggles to 1 within the 5th-bit cycle.
REQ-032 rst pulsed low after bits 1,0,1,1, then j=0,1,0,1,1,0 -> no match on the first 0; w pulses once, after the final 0; match_count=1.
REQ-033 en=0 for 3 cycles inserted between bits 3 and 4 of 10110 -> match still detected; w=0 while en=0 in Mealy mode.
REQ-034 CNT_W=2, 5 matches, then clr_count asserted on the edge of a 6th match -> count reads 1,2,3,3,3, then 0.
